// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the ID-stage hazard/stall controller and the pipeline it steers.
// master = pipeline side (drives decode/load/status info), slave = controller side.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [31:0]      inst;
  logic             use_rs;
  logic             use_rt;
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic             mem_busy;
  logic             branch_taken;
  logic             cnt_clr;
  logic             hazard;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output inst, use_rs, use_rt, id_ex_mem_read, id_ex_rt, mem_busy, branch_taken, cnt_clr,
    input  hazard, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, stall_count
  );

  modport slave (
    input  inst, use_rs, use_rt, id_ex_mem_read, id_ex_rt, mem_busy, branch_taken, cnt_clr,
    output hazard, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard tracker (LOAD_LAT deep) with stall/flush arbitration and a saturating stall counter.
// Controls are combinational (zero latency); mem_busy freezes the pipe and the tracker alike.
module hazard_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave hif
);
  logic [REG_W-1:0]                rs;
  logic [REG_W-1:0]                rt;
  logic [LOAD_LAT-1:0]             trk_vld;
  logic [LOAD_LAT-1:0][REG_W-1:0]  trk_dst;
  logic                            hazard_raw;
  logic                            pc_we;
  logic                            if_id_we;
  logic                            flush;
  logic                            bubble;
  logic                            stall_inc;
  logic [CNT_W-1:0]                stall_cnt;
  logic                            unused_inst;

  assign rs          = REG_W'(hif.inst[25:21]);
  assign rt          = REG_W'(hif.inst[20:16]);
  assign unused_inst = ^{hif.inst[31:26], hif.inst[15:0]};

  // Slot 0 is the load currently in ID/EX; older loads live in the shift slots.
  assign trk_vld[0] = hif.id_ex_mem_read;
  assign trk_dst[0] = hif.id_ex_rt;

  generate
    if (LOAD_LAT > 1) begin : g_slots
      logic [LOAD_LAT-1:1]            slot_vld;
      logic [LOAD_LAT-1:1][REG_W-1:0] slot_dst;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_vld <= '0;
          slot_dst <= '0;
        end else if (!hif.mem_busy) begin
          slot_vld <= trk_vld[LOAD_LAT-2:0];
          slot_dst <= trk_dst[LOAD_LAT-2:0];
        end
      end

      assign trk_vld[LOAD_LAT-1:1] = slot_vld;
      assign trk_dst[LOAD_LAT-1:1] = slot_dst;
    end
  endgenerate

  always_comb begin
    hazard_raw = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (trk_vld[k] && (trk_dst[k] != '0) &&
          ((hif.use_rs && (trk_dst[k] == rs)) || (hif.use_rt && (trk_dst[k] == rt))))
        hazard_raw = 1'b1;
    end
  end

  always_comb begin
    pc_we    = 1'b1;
    if_id_we = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    if (hif.mem_busy) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (hif.branch_taken) begin
      // The ID instruction is wrong-path, so any hazard it has is moot.
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (hazard_raw) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      bubble   = 1'b1;
    end
  end

  assign stall_inc = !hif.mem_busy && !hif.branch_taken && hazard_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hif.cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hif.hazard         = hazard_raw;
  assign hif.pc_write_en    = pc_we;
  assign hif.if_id_write_en = if_id_we;
  assign hif.if_id_flush    = flush;
  assign hif.id_ex_bubble   = bubble;
  assign hif.stall_count    = stall_cnt;
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised load-use hazard and stall controller for the 5-stage pipeline; the successor to the single-cycle load-use detector. It tracks loads still in flight across a configurable number of stages, and stalls the ID instruction only until the load data becomes forwardable. It also arbitrates memory-busy freezes and taken-branch flushes, and keeps a saturating stall-cycle counter for performance measurement. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write and flush controls.

## Interface
- `REG_W`, 5: register-address width.
- `LOAD_LAT`, 1: stages after EX before a load result is forwardable. Legal range 1..4; 1 matches the classic single-bubble behaviour.
- `CNT_W`, 16: width of the stall counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `inst` in 32: instruction in IF/ID; rs = `inst[25:21]`, rt = `inst[20:16]`.
- `use_rs` in 1: the ID instruction reads rs.
- `use_rt` in 1: the ID instruction reads rt.
- `id_ex_mem_read` in 1: the instruction in ID/EX is a load.
- `id_ex_rt` in REG_W: destination of the load in ID/EX.
- `mem_busy` in 1: data memory is not ready; the whole pipe must freeze.
- `branch_taken` in 1: a taken branch was resolved this cycle.
- `cnt_clr` in 1: synchronous clear of `stall_count`.
- `hazard` out 1: raw load-use match (diagnostic).
- `pc_write_en` out 1: PC may update.
- `if_id_write_en` out 1: IF/ID may update.
- `if_id_flush` out 1: zero IF/ID on the next edge.
- `id_ex_bubble` out 1: load a NOP into ID/EX on the next edge.
- `stall_count` out CNT_W: count of load-use stall cycles.

## Operation
- Tracker: slots 1..LOAD_LAT-1, each holding {valid, dst}. Slot 0 is combinational from `id_ex_mem_read`/`id_ex_rt`. For LOAD_LAT=1 no register slots exist.
- A slot matches when it is valid, dst != 0, and dst equals either rs (when `use_rs`) or rt (when `use_rt`). Register 0 never causes a hazard.
- `hazard` = any slot matches.
- Tracker advance: when `mem_busy`=0 on a rising edge, slot1 <= slot0, and slot k <= slot k-1. When `mem_busy`=1, all slots hold.
- Priority, highest first:
  - 1. `mem_busy`: `pc_write_en`=0, `if_id_write_en`=0, `if_id_flush`=0, `id_ex_bubble`=0; the pipe holds.
  - 2. `branch_taken`: `pc_write_en`=1, `if_id_write_en`=1, `if_id_flush`=1, `id_ex_bubble`=1. The wrong-path ID instruction is killed, so its hazard is ignored.
  - 3. `hazard`: `pc_write_en`=0, `if_id_write_en`=0, `if_id_flush`=0, `id_ex_bubble`=1.
  - 4. Otherwise: `pc_write_en`=1, `if_id_write_en`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- A load advances through the tracker while the bubble sits behind it. The ID instruction therefore stalls exactly LOAD_LAT cycles after a back-to-back load-use (distance 1), and LOAD_LAT−d+1 cycles at distance d ≤ LOAD_LAT.
- `stall_count`: +1 on each edge where case 3 is active. It saturates at 2^CNT_W−1, never wrapping. `cnt_clr` sets it to 0 and has priority over increment in the same cycle.

## Timing
- `hazard`, `pc_write_en`, `if_id_write_en`, `if_id_flush` and `id_ex_bubble` are combinational from the inputs and tracker state; zero-cycle latency.
- Tracker and `stall_count` update on the rising `clk` edge.
- Reset (`rst_n`=0, asynchronous): all slot valids = 0, `stall_count` = 0.
  - During reset the control outputs follow slot 0 and the inputs only.
  - With idle inputs the outputs are `pc_write_en`=1, `if_id_write_en`=1, `if_id_flush`=0, `id_ex_bubble`=0, `hazard`=0.
- Reset mid-stall discards all in-flight load tracking. The first post-reset cycle sees only slot 0.
- `mem_busy` asserted during a multi-cycle stall: the stall is extended by the busy cycles, and `stall_count` does not increment while frozen.
- Simultaneous `branch_taken` and `hazard`: no stall, no count increment.

## Test plan
- LOAD_LAT=1: load into r5, next inst `add r1,r5,r2` (`use_rs`=1) -> one cycle of `id_ex_bubble`=1, `pc_write_en`=0; `stall_count`=1.
- LOAD_LAT=3: load r7, then `use_rt` on r7 at distance 1 -> 3 stall cycles; at distance 2 -> 2 cycles; at distance 4 -> 0 cycles.
- Load to r0 followed by a read of r0 -> `hazard`=0, no stall.
- Hazard with `mem_busy`=1 for 2 cycles in the middle of a LOAD_LAT=2 stall -> freeze outputs for those 2 cycles, total stall 2 active cycles, `stall_count`=2.
- `branch_taken`=1 in the same cycle as a load-use match -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_write_en`=1, `stall_count` unchanged.
- CNT_W=4: force 20 stall cycles -> `stall_count` holds at 15. `cnt_clr` together with a stall -> 0. Assert `rst_n`=0 mid-stall -> slots cleared immediately and `stall_count`=0.
